data_scatter: RTL and testbench

Write-side counterpart of `data_selector`. It accepts a 16-bit word of four 4-bit nibbles and writes each nibble into an eight-register, 32-bit-per-register nibble bank, which is exposed as `wRegs0`..`wRegs7`. Each nibble's destination comes from a per-word destination vector. Writes are serialized one nibble per cycle under a busy/done handshake. The block sits between a processing stage and the register bank that `data_selector` reads from.

---
 rtl/data_scatter.sv | 139 +++++++++++++
 tb/tb_data_scatter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/data_scatter.sv
// Serialising nibble scatter: captures a 16-bit word plus per-nibble destinations
// and writes one nibble per cycle into an 8 x 32-bit register bank.
module data_scatter #(
  parameter int DATA_WIDTH           = 4,
  parameter int IN_NIBBLES           = 4,
  parameter int REGS_OUTPUTS         = 64,
  parameter int REGS_BITS_PER_OUTPUT = 32,
  parameter int DEST_BITS            = 6
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_WIDTH*IN_NIBBLES-1:0]   data_in,
  input  logic                               data_valid,
  input  logic [DEST_BITS*IN_NIBBLES-1:0]    wDest,
  input  logic [IN_NIBBLES-1:0]              wMask,
  output logic                               wBusy,
  output logic                               done,
  output logic [REGS_BITS_PER_OUTPUT-1:0]    wRegs0,
  output logic [REGS_BITS_PER_OUTPUT-1:0]    wRegs1,
  output logic [REGS_BITS_PER_OUTPUT-1:0]    wRegs2,
  output logic [REGS_BITS_PER_OUTPUT-1:0]    wRegs3,
  output logic [REGS_BITS_PER_OUTPUT-1:0]    wRegs4,
  output logic [REGS_BITS_PER_OUTPUT-1:0]    wRegs5,
  output logic [REGS_BITS_PER_OUTPUT-1:0]    wRegs6,
  output logic [REGS_BITS_PER_OUTPUT-1:0]    wRegs7
);

  localparam int SLOTS_PER_REG = REGS_BITS_PER_OUTPUT / DATA_WIDTH;
  localparam int NUM_REGS      = REGS_OUTPUTS / SLOTS_PER_REG;
  localparam int POS_BITS      = $clog2(SLOTS_PER_REG);
  localparam int REG_BITS      = DEST_BITS - POS_BITS;
  localparam int K_BITS        = $clog2(IN_NIBBLES);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} stateT;

  stateT                           state, nextState;
  logic [K_BITS-1:0]               k, nextK;
  logic                            capture;
  logic                            wrEn;
  logic [DEST_BITS-1:0]            curDest;
  logic [REG_BITS-1:0]             wrReg;
  logic [POS_BITS-1:0]             wrPos;
  logic [DATA_WIDTH-1:0]           wrNibble;

  logic [DATA_WIDTH*IN_NIBBLES-1:0] shData;
  logic [DEST_BITS*IN_NIBBLES-1:0]  shDest;
  logic [IN_NIBBLES-1:0]            shMask;
  logic [REGS_BITS_PER_OUTPUT-1:0]  bank [NUM_REGS];

  // DONE hands straight over to a new word when one is waiting, so a requester
  // holding data_valid gets one word accepted every five cycles.
  always_comb begin
    nextState = state;
    nextK     = k;
    capture   = 1'b0;
    wrEn      = 1'b0;
    curDest   = shDest[int'(k)*DEST_BITS +: DEST_BITS];
    wrReg     = curDest[DEST_BITS-1 -: REG_BITS];
    wrPos     = curDest[POS_BITS-1:0];
    wrNibble  = shData[int'(k)*DATA_WIDTH +: DATA_WIDTH];
    case (state)
      IDLE: begin
        if (data_valid) begin
          capture   = 1'b1;
          nextK     = '0;
          nextState = WRITE;
        end
      end
      WRITE: begin
        wrEn = shMask[k];
        if (k == K_BITS'(IN_NIBBLES - 1)) nextState = DONE;
        else                              nextK     = k + K_BITS'(1);
      end
      DONE: begin
        if (data_valid) begin
          capture   = 1'b1;
          nextK     = '0;
          nextState = WRITE;
        end else begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // NOTE: state elements use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      wBusy <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= nextState;
      k     <= nextK;
      wBusy <= (nextState != IDLE);
      done  <= (nextState == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shData <= '0;
      shDest <= '0;
      shMask <= '0;
    end else if (capture) begin
      shData <= data_in;
      shDest <= wDest;
      shMask <= wMask;
    end
  end

  // NOTE: the bank is built from flops rather than a RAM macro, which is what
  // lets reset clear every register in a single edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) bank[r] <= '0;
    end else if (wrEn) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        for (int n = 0; n < SLOTS_PER_REG; n++) begin
          if (wrReg == REG_BITS'(r) && wrPos == POS_BITS'(n))
            bank[r][n*DATA_WIDTH +: DATA_WIDTH] <= wrNibble;
        end
      end
    end
  end

  assign wRegs0 = bank[0];
  assign wRegs1 = bank[1];
  assign wRegs2 = bank[2];
  assign wRegs3 = bank[3];
  assign wRegs4 = bank[4];
  assign wRegs5 = bank[5];
  assign wRegs6 = bank[6];
  assign wRegs7 = bank[7];

endmodule

// File: tb/tb_data_scatter.sv
// Randomised bench for data_scatter, compared every cycle against an
// array-based model of the nibble bank.
module tb_data_scatter;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_valid;
  logic [15:0] data_in;
  logic [23:0] wDest;
  logic [3:0]  wMask;
  logic        wBusy;
  logic        done;
  logic [31:0] wRegs0, wRegs1, wRegs2, wRegs3, wRegs4, wRegs5, wRegs6, wRegs7;

  logic [7:0][31:0] obsBank;
  logic [7:0][31:0] modelBank;
  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  data_scatter dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .wDest(wDest), .wMask(wMask), .wBusy(wBusy), .done(done),
    .wRegs0(wRegs0), .wRegs1(wRegs1), .wRegs2(wRegs2), .wRegs3(wRegs3),
    .wRegs4(wRegs4), .wRegs5(wRegs5), .wRegs6(wRegs6), .wRegs7(wRegs7)
  );

  assign obsBank = {wRegs7, wRegs6, wRegs5, wRegs4, wRegs3, wRegs2, wRegs1, wRegs0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: nibble k of a word lands at register dst[5:3], slot dst[2:0].
  task automatic modelWrite(input logic [15:0] d, input logic [23:0] dst,
                            input logic [3:0] m, input int k);
    logic [5:0] a;
    a = dst[6*k +: 6];
    if (m[k]) modelBank[a[5:3]][4*a[2:0] +: 4] = d[4*k +: 4];
  endtask

  task automatic runWord(input logic [15:0] d, input logic [23:0] dst,
                         input logic [3:0] m, input string tag);
    data_in = d; wDest = dst; wMask = m; data_valid = 1'b1;
    tick();
    nChecks++;
    if (wBusy !== 1'b1 || done !== 1'b0 || obsBank !== modelBank) begin
      nFails++;
      $display("FAIL %s accept: busy=%b done=%b bank=%h, want busy=1 done=0 bank=%h",
               tag, wBusy, done, obsBank, modelBank);
    end
    for (int k = 0; k < 4; k++) begin
      data_valid = 1'($urandom_range(0, 1));
      data_in    = 16'($urandom);
      wDest      = 24'($urandom);
      wMask      = 4'($urandom);
      tick();
      modelWrite(d, dst, m, k);
      nChecks++;
      if (wBusy !== 1'b1 || done !== (k == 3) || obsBank !== modelBank) begin
        nFails++;
        $display("FAIL %s nibble%0d: busy=%b done=%b bank=%h, want busy=1 done=%b bank=%h",
                 tag, k, wBusy, done, obsBank, (k == 3), modelBank);
      end
    end
    data_valid = 1'b0;
    tick();
    nChecks++;
    if (wBusy !== 1'b0 || done !== 1'b0 || obsBank !== modelBank) begin
      nFails++;
      $display("FAIL %s idle: busy=%b done=%b bank=%h, want busy=0 done=0 bank=%h",
               tag, wBusy, done, obsBank, modelBank);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; data_valid = 1'b0; data_in = '0; wDest = '0; wMask = '0;
    tick();
    tick();
    modelBank = '0;
    nChecks++;
    if (wBusy !== 1'b0 || done !== 1'b0 || obsBank !== modelBank) begin
      nFails++;
      $display("FAIL reset: busy=%b done=%b bank=%h, want all zero", wBusy, done, obsBank);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      data_in = 16'($urandom); wDest = 24'($urandom); wMask = 4'($urandom);
      tick();
      nChecks++;
      if ({wBusy, done, obsBank} !== '0) begin
        nFails++;
        $display("FAIL reset_idle cycle%0d: busy=%b done=%b bank=%h, want all zero",
                 i, wBusy, done, obsBank);
      end
    end
  endtask

  task automatic test_basic();
    runWord(16'hABCD, {6'd3, 6'd2, 6'd1, 6'd0}, 4'hF, "basic");
    nChecks++;
    if (wRegs0 !== 32'h0000_ABCD) begin
      nFails++;
      $display("FAIL basic_final: wRegs0=%h, want 0000abcd", wRegs0);
    end
  endtask

  task automatic test_extremes();
    runWord(16'h1234, {6'd63, 6'd56, 6'd7, 6'd0}, 4'b1010, "extremes");
    nChecks++;
    if (wRegs7 !== 32'h1000_0000) begin
      nFails++;
      $display("FAIL extremes_reg7: wRegs7=%h, want 10000000", wRegs7);
    end
  endtask

  task automatic test_collision();
    runWord(16'h5678, {4{6'd9}}, 4'hF, "collision");
    nChecks++;
    if (wRegs1[7:4] !== 4'h5) begin
      nFails++;
      $display("FAIL collision: wRegs1[7:4]=%h, want 5", wRegs1[7:4]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      runWord(16'($urandom), 24'($urandom), 4'($urandom), "random");
  endtask

  task automatic test_back_to_back();
    logic [15:0] curD, capD;
    logic [23:0] curDst, capDst;
    logic [3:0]  curM, capM;
    int phase;
    capD = '0; capDst = '0; capM = '0;
    data_valid = 1'b1;
    for (int t = 0; t < 25; t++) begin
      curD = 16'($urandom); curDst = 24'($urandom); curM = 4'($urandom);
      data_in = curD; wDest = curDst; wMask = curM;
      tick();
      phase = t % 5;
      if (phase == 0) begin
        capD = curD; capDst = curDst; capM = curM;
      end else begin
        modelWrite(capD, capDst, capM, phase - 1);
      end
      nChecks++;
      if (wBusy !== 1'b1 || done !== (phase == 4) || obsBank !== modelBank) begin
        nFails++;
        $display("FAIL back_to_back t%0d: busy=%b done=%b bank=%h, want busy=1 done=%b bank=%h",
                 t, wBusy, done, obsBank, (phase == 4), modelBank);
      end
    end
    data_valid = 1'b0;
    tick();
    nChecks++;
    if (wBusy !== 1'b0 || done !== 1'b0 || obsBank !== modelBank) begin
      nFails++;
      $display("FAIL back_to_back_end: busy=%b done=%b bank=%h, want busy=0 done=0 bank=%h",
               wBusy, done, obsBank, modelBank);
    end
  endtask

  task automatic test_reset_midop();
    logic [15:0] d;
    logic [23:0] dst;
    d = 16'($urandom); dst = 24'($urandom);
    data_in = d; wDest = dst; wMask = 4'hF; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    modelWrite(d, dst, 4'hF, 0);
    nChecks++;
    if (obsBank !== modelBank) begin
      nFails++;
      $display("FAIL midop_pre: bank=%h, want %h", obsBank, modelBank);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelBank = '0;
    nChecks++;
    if (wBusy !== 1'b0 || done !== 1'b0 || obsBank !== modelBank) begin
      nFails++;
      $display("FAIL midop_reset: busy=%b done=%b bank=%h, want all zero", wBusy, done, obsBank);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      nChecks++;
      if ({wBusy, done, obsBank} !== '0) begin
        nFails++;
        $display("FAIL midop_quiet cycle%0d: busy=%b done=%b bank=%h, want all zero",
                 i, wBusy, done, obsBank);
      end
    end
    runWord(16'($urandom), 24'($urandom), 4'hF, "after_reset");
  endtask

  initial begin
    rst = 1'b1; data_valid = 1'b0; data_in = '0; wDest = '0; wMask = '0;
    modelBank = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_collision();
    test_random();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
